aes_bist_sequencer: RTL and testbench

Synthesizable built-in self-test sequencer for `aes128_hardened_top`. It replays NUM_VECTORS known-answer vectors from an external vector ROM through the AES core and compares every ciphertext. It then optionally runs one fault-injection pass that must raise the core's fault alert. The block sits between the SoC control register block and the hardened AES core, and it owns the core's request port while a self-test is running.

---
 rtl/aes_bist_sequencer_if.sv | 20 ++
 rtl/aes_bist_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_bist_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_bist_sequencer_if.sv
// Request/response port between the BIST sequencer (master) and the hardened AES core (slave).
interface aes_bist_sequencer_if;
    logic         aes_start;
    logic [127:0] aes_key;
    logic [127:0] aes_plaintext;
    logic         aes_inject_fault;
    logic [127:0] aes_ciphertext;
    logic         aes_valid;
    logic         aes_fault_alert;

    modport master (
        output aes_start, aes_key, aes_plaintext, aes_inject_fault,
        input  aes_ciphertext, aes_valid, aes_fault_alert
    );

    modport slave (
        input  aes_start, aes_key, aes_plaintext, aes_inject_fault,
        output aes_ciphertext, aes_valid, aes_fault_alert
    );
endinterface

// File: rtl/aes_bist_sequencer.sv
// Known-answer self-test sequencer for the hardened AES core, with an optional fault-injection
// pass compiled in by AES_BIST_FAULT_CHECK_EN.
module aes_bist_sequencer #(
    parameter int  NUM_VECTORS    = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int IDX_W          = $clog2(NUM_VECTORS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bist_start_i,
    output logic                 bist_busy_o,
    output logic                 bist_done_o,
    output logic                 bist_pass_o,
    output logic [2:0]           bist_fail_code_o,
    output logic [IDX_W-1:0]     fail_index_o,
    output logic [IDX_W-1:0]     pass_count_o,
    output logic [IDX_W-1:0]     vec_index_o,
    input  logic [127:0]         vec_key_i,
    input  logic [127:0]         vec_plain_i,
    input  logic [127:0]         vec_expect_i,
    aes_bist_sequencer_if.master aes
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_FAULT_ISSUE, S_FAULT_WAIT, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE       = 3'd0,
        FC_MISMATCH   = 3'd1,
        FC_ALERT      = 3'd2,
        FC_TIMEOUT    = 3'd3,
        FC_UNDETECTED = 3'd4
    } fail_code_e;

    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
`ifdef AES_BIST_FAULT_CHECK_EN
    localparam logic [IDX_W-1:0] FAULT_IDX = IDX_W'(NUM_VECTORS);
`endif

    state_e           state_q, state_d;
    fail_code_e       code_q, code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             start_q, start_d;
    logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
    logic [IDX_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [TO_W-1:0]  tmo_q, tmo_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     plain_q, plain_d;
    logic [127:0]     expect_q, expect_d;
`ifdef AES_BIST_FAULT_CHECK_EN
    logic             inject_q, inject_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        code_d     = code_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        start_d    = 1'b0;
        fail_idx_d = fail_idx_q;
        pass_cnt_d = pass_cnt_q;
        vec_idx_d  = vec_idx_q;
        tmo_d      = tmo_q;
        key_d      = key_q;
        plain_d    = plain_q;
        expect_d   = expect_q;
`ifdef AES_BIST_FAULT_CHECK_EN
        inject_d   = inject_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bist_start_i) begin
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    code_d     = FC_NONE;
                    fail_idx_d = '0;
                    pass_cnt_d = '0;
                    vec_idx_d  = '0;
                    start_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                key_d    = vec_key_i;
                plain_d  = vec_plain_i;
                expect_d = vec_expect_i;
                tmo_d    = '0;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                tmo_d = tmo_q + TO_W'(1);
                if (aes.aes_fault_alert) begin
                    code_d     = FC_ALERT;
                    fail_idx_d = vec_idx_q;
                    state_d    = S_DONE;
                end else if (aes.aes_valid) begin
                    if (aes.aes_ciphertext != expect_q) begin
                        code_d     = FC_MISMATCH;
                        fail_idx_d = vec_idx_q;
                        state_d    = S_DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + IDX_W'(1);
                        if (vec_idx_q == LAST_IDX) begin
`ifdef AES_BIST_FAULT_CHECK_EN
                            vec_idx_d = '0;
                            inject_d  = 1'b1;
                            start_d   = 1'b1;
                            state_d   = S_FAULT_ISSUE;
`else
                            state_d   = S_DONE;
`endif
                        end else begin
                            vec_idx_d = vec_idx_q + IDX_W'(1);
                            start_d   = 1'b1;
                            state_d   = S_ISSUE;
                        end
                    end
                end else if (tmo_q == TO_LAST) begin
                    // A response in the final WAIT cycle is handled above and beats the timeout.
                    code_d     = FC_TIMEOUT;
                    fail_idx_d = vec_idx_q;
                    state_d    = S_DONE;
                end
            end

`ifdef AES_BIST_FAULT_CHECK_EN
            S_FAULT_ISSUE: begin
                key_d   = vec_key_i;
                plain_d = vec_plain_i;
                tmo_d   = '0;
                state_d = S_FAULT_WAIT;
            end

            S_FAULT_WAIT: begin
                tmo_d = tmo_q + TO_W'(1);
                if (aes.aes_fault_alert) begin
                    state_d = S_DONE;
                end else if (aes.aes_valid) begin
                    code_d     = FC_UNDETECTED;
                    fail_idx_d = FAULT_IDX;
                    state_d    = S_DONE;
                end else if (tmo_q == TO_LAST) begin
                    code_d     = FC_TIMEOUT;
                    fail_idx_d = FAULT_IDX;
                    state_d    = S_DONE;
                end
            end
`endif

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        // Result, done pulse and inject release are all registered on the edge entering DONE.
        if (state_d == S_DONE && state_q != S_DONE) begin
            done_d = 1'b1;
            pass_d = (code_d == FC_NONE);
`ifdef AES_BIST_FAULT_CHECK_EN
            inject_d = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the wide operand and expect
    // registers are reset too, because the core port must read as all-zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= FC_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            start_q    <= 1'b0;
            fail_idx_q <= '0;
            pass_cnt_q <= '0;
            vec_idx_q  <= '0;
            tmo_q      <= '0;
            key_q      <= '0;
            plain_q    <= '0;
            expect_q   <= '0;
`ifdef AES_BIST_FAULT_CHECK_EN
            inject_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            start_q    <= start_d;
            fail_idx_q <= fail_idx_d;
            pass_cnt_q <= pass_cnt_d;
            vec_idx_q  <= vec_idx_d;
            tmo_q      <= tmo_d;
            key_q      <= key_d;
            plain_q    <= plain_d;
            expect_q   <= expect_d;
`ifdef AES_BIST_FAULT_CHECK_EN
            inject_q   <= inject_d;
`endif
        end
    end

    assign bist_busy_o      = busy_q;
    assign bist_done_o      = done_q;
    assign bist_pass_o      = pass_q;
    assign bist_fail_code_o = code_q;
    assign fail_index_o     = fail_idx_q;
    assign pass_count_o     = pass_cnt_q;
    assign vec_index_o      = vec_idx_q;

    // Operands settle on the edge that ends the start cycle and stay stable through WAIT.
    assign aes.aes_start     = start_q;
    assign aes.aes_key       = key_q;
    assign aes.aes_plaintext = plain_q;
`ifdef AES_BIST_FAULT_CHECK_EN
    assign aes.aes_inject_fault = inject_q;
`else
    assign aes.aes_inject_fault = 1'b0;
`endif

endmodule

// File: tb/tb_aes_bist_sequencer.sv
// Self-checking bench for aes_bist_sequencer: scenario table, behavioural core model with
// latency 11, and a result scoreboard popped on every bist_done pulse.
module tb_aes_bist_sequencer;

    localparam int NV  = 4;
    localparam int TMO = 64;
    localparam int LAT = 11;
    localparam int IW  = 3;
`ifdef AES_BIST_FAULT_CHECK_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef enum int {CM_NORMAL, CM_HANG1, CM_BOTH0, CM_NOALERT} core_mode_e;

    typedef struct {
        core_mode_e mode;
        int         corrupt;
        bit         pass;
        logic [2:0] code;
        int         fidx;
        int         pcnt;
        int         starts;
        bit         inj;
        int         cycles;
    } scen_t;

    typedef struct {
        bit         pass;
        logic [2:0] code;
        int         fidx;
        int         pcnt;
    } result_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bist_start;
    logic          bist_busy, bist_done, bist_pass;
    logic [2:0]    bist_fail_code;
    logic [IW-1:0] fail_index, pass_count, vec_index;
    logic [127:0]  vec_key, vec_plain, vec_expect;

    logic [127:0] rom_key[NV];
    logic [127:0] rom_pt[NV];
    logic [127:0] rom_exp[NV];
    logic [127:0] gold_ct[NV];

    scen_t      tbl[5];
    result_t    exp_q[$];
    core_mode_e mode = CM_NORMAL;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    aes_bist_sequencer_if bus();

    aes_bist_sequencer #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bist_start_i(bist_start),
        .bist_busy_o(bist_busy), .bist_done_o(bist_done), .bist_pass_o(bist_pass),
        .bist_fail_code_o(bist_fail_code), .fail_index_o(fail_index),
        .pass_count_o(pass_count), .vec_index_o(vec_index),
        .vec_key_i(vec_key), .vec_plain_i(vec_plain), .vec_expect_i(vec_expect),
        .aes(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vec_key    = (int'(vec_index) < NV) ? rom_key[vec_index[1:0]] : '0;
    assign vec_plain  = (int'(vec_index) < NV) ? rom_pt[vec_index[1:0]]  : '0;
    assign vec_expect = (int'(vec_index) < NV) ? rom_exp[vec_index[1:0]] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Core model: counts LAT falling edges from the start cycle, then strobes the response.
    int  starts = 0, injects = 0, inj_cycles = 0, hang_cyc = 0;
    int  core_cnt = 0, cur_idx = 0, ops_idx = 0;
    bit  core_busy = 1'b0, cur_inj = 1'b0, check_ops = 1'b0;

    always @(negedge clk) begin
        if (bus.aes_inject_fault === 1'b1) inj_cycles++;
        if (!rst_n) begin
            core_busy            = 1'b0;
            check_ops            = 1'b0;
            bus.aes_valid        = 1'b0;
            bus.aes_fault_alert  = 1'b0;
            bus.aes_ciphertext   = '0;
        end else begin
            bus.aes_valid       = 1'b0;
            bus.aes_fault_alert = 1'b0;
            if (check_ops) begin
                check($sformatf("operand key v%0d", ops_idx), bus.aes_key, rom_key[ops_idx]);
                check($sformatf("operand pt v%0d", ops_idx), bus.aes_plaintext, rom_pt[ops_idx]);
                check_ops = 1'b0;
            end
            if (core_busy) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_busy = 1'b0;
                    if (cur_inj) begin
                        if (mode == CM_NOALERT) begin
                            bus.aes_valid      = 1'b1;
                            bus.aes_ciphertext = gold_ct[0];
                        end else begin
                            bus.aes_fault_alert = 1'b1;
                        end
                    end else begin
                        bus.aes_valid      = 1'b1;
                        bus.aes_ciphertext = gold_ct[cur_idx];
                        if (mode == CM_BOTH0 && cur_idx == 0) bus.aes_fault_alert = 1'b1;
                    end
                end
            end
            if (bus.aes_start === 1'b1) begin
                starts++;
                cur_inj = bus.aes_inject_fault;
                if (cur_inj) injects++;
                cur_idx   = int'(vec_index);
                ops_idx   = cur_inj ? 0 : cur_idx;
                check_ops = 1'b1;
                if (mode == CM_HANG1 && !cur_inj && cur_idx == 1) begin
                    hang_cyc = cyc;
                end else begin
                    core_busy = 1'b1;
                    core_cnt  = LAT;
                end
            end
        end
    end

    task automatic wait_done(input bit pulses, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            bist_start = pulses && (k == 5 || k == 25);
            if (bist_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bist_start = 1'b0;
        if (!ok) check("bist_done within bound", 1'b0, 1'b1);
    endtask

    task automatic run_scen(input int i, input bit pulses);
        result_t r;
        int      s0, j0, ic0, start_cyc, ref_cyc;
        bit      ok;
        mode = tbl[i].mode;
        for (int v = 0; v < NV; v++)
            rom_exp[v] = (v == tbl[i].corrupt) ? (gold_ct[v] ^ 128'h1) : gold_ct[v];
        s0  = starts;
        j0  = injects;
        ic0 = inj_cycles;
        @(negedge clk);
        bist_start = 1'b1;
        exp_q.push_back('{tbl[i].pass, tbl[i].code, tbl[i].fidx, tbl[i].pcnt});
        @(negedge clk);
        bist_start = 1'b0;
        start_cyc  = cyc;
        check($sformatf("s%0d aes_start after accept", i), bus.aes_start, 1'b1);
        check($sformatf("s%0d busy after accept", i), bist_busy, 1'b1);
        check($sformatf("s%0d pass cleared", i), bist_pass, 1'b0);
        wait_done(pulses, ok);
        if (ok) begin
            r = exp_q.pop_front();
            check($sformatf("s%0d bist_pass", i), bist_pass, r.pass);
            check($sformatf("s%0d fail_code", i), bist_fail_code, r.code);
            check($sformatf("s%0d fail_index", i), fail_index, r.fidx);
            check($sformatf("s%0d pass_count", i), pass_count, r.pcnt);
            check($sformatf("s%0d busy in DONE", i), bist_busy, 1'b1);
            check($sformatf("s%0d aes_start count", i), starts - s0, tbl[i].starts);
            check($sformatf("s%0d inject starts", i), injects - j0, int'(tbl[i].inj));
            check($sformatf("s%0d inject seen", i), (inj_cycles - ic0) != 0, tbl[i].inj);
            if (tbl[i].cycles >= 0) begin
                ref_cyc = (tbl[i].mode == CM_HANG1) ? hang_cyc : start_cyc;
                check($sformatf("s%0d cycles to done", i), cyc - ref_cyc, tbl[i].cycles);
            end
            @(negedge clk);
            check($sformatf("s%0d done one cycle", i), bist_done, 1'b0);
            check($sformatf("s%0d busy released", i), bist_busy, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, bist_busy, 1'b0);
        check({tag, " done"}, bist_done, 1'b0);
        check({tag, " pass"}, bist_pass, 1'b0);
        check({tag, " code"}, bist_fail_code, 3'd0);
        check({tag, " fail_index"}, fail_index, '0);
        check({tag, " pass_count"}, pass_count, '0);
        check({tag, " vec_index"}, vec_index, '0);
        check({tag, " aes_start"}, bus.aes_start, 1'b0);
        check({tag, " aes_key"}, bus.aes_key, '0);
        check({tag, " aes_plaintext"}, bus.aes_plaintext, '0);
        check({tag, " aes_inject_fault"}, bus.aes_inject_fault, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0;
        rom_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        rom_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        gold_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        rom_key[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rom_pt[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        gold_ct[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        rom_key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rom_pt[2]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        gold_ct[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        rom_key[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rom_pt[3]  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        gold_ct[3] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        for (int v = 0; v < NV; v++) rom_exp[v] = gold_ct[v];

        //            mode        corrupt pass  code  fidx            pcnt starts        inj cycles
        tbl[0] = '{CM_NORMAL,  -1, 1'b1, 3'd0, 0,              NV,  NV + int'(FE), FE, FE ? 60 : 48};
        tbl[1] = '{CM_NORMAL,   2, 1'b0, 3'd1, 2,              2,   3,             1'b0, 36};
        tbl[2] = '{CM_HANG1,   -1, 1'b0, 3'd3, 1,              1,   2,             1'b0, TMO + 1};
        tbl[3] = '{CM_BOTH0,   -1, 1'b0, 3'd2, 0,              0,   1,             1'b0, 12};
        tbl[4] = '{CM_NOALERT, -1, !FE,  FE ? 3'd4 : 3'd0, FE ? NV : 0, NV, NV + int'(FE), FE, -1};

        rst_n      = 1'b0;
        bist_start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #2 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_scen(i, 1'b0);

        // Abort a run with reset while vector 1 is in WAIT.
        mode = CM_NORMAL;
        for (int v = 0; v < NV; v++) rom_exp[v] = gold_ct[v];
        s0 = starts;
        @(negedge clk);
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (starts - s0 >= 2) break;
        end
        repeat (3) @(negedge clk);
        check("midrun vec_index", vec_index, 1);
        check("midrun aes_key", bus.aes_key, rom_key[1]);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrun reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Fresh run with extra start pulses while busy.
        run_scen(0, 1'b1);
        s0 = starts;
        repeat (4) @(negedge clk);
        check("idle after ignored pulses busy", bist_busy, 1'b0);
        check("idle after ignored pulses starts", starts - s0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
